// File: rtl/cash_backing_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cash_backing_responder_pkg
// Purpose  : Shared types and constants for the cash backing-store responder:
//            FSM state encoding and latency-timer width.
// Ports    : none (package)
// Config   : CASH_RESPONDER_STATS_EN (used by the top module, not here)
// Revision : 1.0 - initial release
// ============================================================================
package cash_backing_responder_pkg;

  // Latency timers are 4 bits wide, which covers latencies of 1..15 cycles.
  localparam int CASH_LATENCY_W = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_WAIT  = 3'd1,
    PRESENT    = 3'd2,
    WRITE_WAIT = 3'd3,
    HANDLED    = 3'd4
  } cash_responder_state_t;

endpackage : cash_backing_responder_pkg
`default_nettype wire

// File: rtl/cash_backing_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : cash_backing_responder_if
// Purpose  : Fetch / unload handshake between the cache (master) and the
//            backing-store responder (slave).
// Signals  : request_string, fetch_address          cache -> responder
//            fetch_data_presented, fetch_data       responder -> cache
//            unload_request, unload_address/data    cache -> responder
//            unloaded_data_handled, busy            responder -> cache
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
interface cash_backing_responder_if #(
  parameter int ADDRESS_SIZE = 4,
  parameter int DATA_SIZE    = 8
);

  logic                    request_string;
  logic [ADDRESS_SIZE-1:0] fetch_address;
  logic                    fetch_data_presented;
  logic [DATA_SIZE-1:0]    fetch_data;
  logic                    unload_request;
  logic [ADDRESS_SIZE-1:0] unload_address;
  logic [DATA_SIZE-1:0]    unload_data;
  logic                    unloaded_data_handled;
  logic                    busy;

  modport master (
    output request_string, fetch_address,
    output unload_request, unload_address, unload_data,
    input  fetch_data_presented, fetch_data,
    input  unloaded_data_handled, busy
  );

  modport slave (
    input  request_string, fetch_address,
    input  unload_request, unload_address, unload_data,
    output fetch_data_presented, fetch_data,
    output unloaded_data_handled, busy
  );

endinterface : cash_backing_responder_if
`default_nettype wire

// File: rtl/cash_backing_responder_latency_timer.sv
`default_nettype none
// ============================================================================
// Module   : cash_backing_responder_latency_timer
// Purpose  : Loadable down-counter with a zero flag; times both the read and
//            the write wait of the responder.
// Ports    : clk, reset (async active-low)
//            i_load / i_load_value : load a new count (wins over decrement)
//            i_dec                 : decrement, holds at zero
//            o_zero                : count is zero
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module cash_backing_responder_latency_timer
  import cash_backing_responder_pkg::*;
(
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      i_load,
  input  wire logic [CASH_LATENCY_W-1:0] i_load_value,
  input  wire logic                      i_dec,
  output logic                           o_zero
);

  logic [CASH_LATENCY_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CASH_LATENCY_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule : cash_backing_responder_latency_timer
`default_nettype wire

// File: rtl/cash_backing_responder.sv
`default_nettype none
// ============================================================================
// Module   : cash_backing_responder
// Purpose  : Memory-side responder for the cache. Serves fetches from a local
//            2**ADDRESS_SIZE-word array and writes back evicted words, each
//            with a fixed latency, signalled by one-cycle pulses.
// Ports    : clk, reset (async active-low)
//            bus   : cash_backing_responder_if.slave (fetch/unload handshake)
//            fetch_count, unload_count : saturating pulse counters
//                    (only with CASH_RESPONDER_STATS_EN)
// Config   : CASH_RESPONDER_STATS_EN - adds the statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module cash_backing_responder
  import cash_backing_responder_pkg::*;
#(
  parameter int ADDRESS_SIZE  = 4,
  parameter int DATA_SIZE     = 8,
  parameter int READ_LATENCY  = 2,   // 1..15
  parameter int WRITE_LATENCY = 1    // 1..15
`ifdef CASH_RESPONDER_STATS_EN
  ,
  parameter int STAT_WIDTH    = 16
`endif
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  cash_backing_responder_if.slave   bus
`ifdef CASH_RESPONDER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]     fetch_count,
  output logic [STAT_WIDTH-1:0]     unload_count
`endif
);

  localparam int DEPTH = 2 ** ADDRESS_SIZE;

  // Timer is loaded with latency-1: the transition out of the wait state
  // consumes the final cycle.
  localparam logic [CASH_LATENCY_W-1:0] c_read_load  = CASH_LATENCY_W'(READ_LATENCY - 1);
  localparam logic [CASH_LATENCY_W-1:0] c_write_load = CASH_LATENCY_W'(WRITE_LATENCY - 1);

  cash_responder_state_t     r_state;
  cash_responder_state_t     w_state_next;

  logic [ADDRESS_SIZE-1:0]   r_addr;
  logic [DATA_SIZE-1:0]      r_wdata;
  logic [DATA_SIZE-1:0]      r_fetch_data;
  logic [DATA_SIZE-1:0]      r_mem [DEPTH];

  logic                      w_timer_load;
  logic [CASH_LATENCY_W-1:0] w_timer_value;
  logic                      w_timer_dec;
  logic                      w_timer_zero;
  logic                      w_accept_unload;
  logic                      w_accept_fetch;
  logic                      w_read_done;
  logic                      w_write_done;

  cash_backing_responder_latency_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_timer_load),
    .i_load_value (w_timer_value),
    .i_dec        (w_timer_dec),
    .o_zero       (w_timer_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_timer_load    = 1'b0;
    w_timer_value   = '0;
    w_timer_dec     = 1'b0;
    w_accept_unload = 1'b0;
    w_accept_fetch  = 1'b0;
    w_read_done     = 1'b0;
    w_write_done    = 1'b0;
    case (r_state)
      IDLE: begin
        // Eviction has priority so a fetch of the same address sees new data.
        if (bus.unload_request) begin
          w_accept_unload = 1'b1;
          w_timer_load    = 1'b1;
          w_timer_value   = c_write_load;
          w_state_next    = WRITE_WAIT;
        end else if (bus.request_string) begin
          w_accept_fetch  = 1'b1;
          w_timer_load    = 1'b1;
          w_timer_value   = c_read_load;
          w_state_next    = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (w_timer_zero) begin
          w_read_done  = 1'b1;
          w_state_next = PRESENT;
        end else begin
          w_timer_dec  = 1'b1;
        end
      end
      PRESENT:    w_state_next = IDLE;
      WRITE_WAIT: begin
        if (w_timer_zero) begin
          w_write_done = 1'b1;
          w_state_next = HANDLED;
        end else begin
          w_timer_dec  = 1'b1;
        end
      end
      HANDLED:    w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
  end

  // Datapath: request fields are captured at accept so later input changes
  // have no effect on the transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_fetch_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_accept_unload) begin
        r_addr  <= bus.unload_address;
        r_wdata <= bus.unload_data;
      end else if (w_accept_fetch) begin
        r_addr  <= bus.fetch_address;
      end
      if (w_write_done) begin
        r_mem[r_addr] <= r_wdata;
      end
      if (w_read_done) begin
        r_fetch_data <= r_mem[r_addr];
      end
    end
  end

  assign bus.fetch_data_presented  = (r_state == PRESENT);
  assign bus.unloaded_data_handled = (r_state == HANDLED);
  assign bus.busy                  = (r_state != IDLE);
  assign bus.fetch_data            = r_fetch_data;

`ifdef CASH_RESPONDER_STATS_EN
  logic [STAT_WIDTH-1:0] r_fetch_count;
  logic [STAT_WIDTH-1:0] r_unload_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_count  <= '0;
      r_unload_count <= '0;
    end else begin
      if ((r_state == PRESENT) && (r_fetch_count != '1)) begin
        r_fetch_count <= r_fetch_count + STAT_WIDTH'(1);
      end
      if ((r_state == HANDLED) && (r_unload_count != '1)) begin
        r_unload_count <= r_unload_count + STAT_WIDTH'(1);
      end
    end
  end

  assign fetch_count  = r_fetch_count;
  assign unload_count = r_unload_count;
`endif

endmodule : cash_backing_responder
`default_nettype wire

// File: tb/tb_cash_backing_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cash_backing_responder
// Purpose  : Self-checking bench for cash_backing_responder: directed vector
//            table, hand-written corner sequences and random traffic checked
//            against a plain memory model with fixed latencies.
// Config   : CASH_RESPONDER_STATS_EN - also checks the statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module tb_cash_backing_responder;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int RL  = 2;
  localparam int WL  = 1;
  localparam int MAX_WAIT = 40;
`ifdef CASH_RESPONDER_STATS_EN
  localparam int SW  = 2;
  logic [SW-1:0] fetch_count;
  logic [SW-1:0] unload_count;
`endif

  logic clk;
  logic reset;

  cash_backing_responder_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

  cash_backing_responder #(
    .ADDRESS_SIZE  (AW),
    .DATA_SIZE     (DW),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
`ifdef CASH_RESPONDER_STATS_EN
    ,
    .STAT_WIDTH    (SW)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CASH_RESPONDER_STATS_EN
    ,
    .fetch_count  (fetch_count),
    .unload_count (unload_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference memory: just the array contents, updated when an unload is issued.
  logic [DW-1:0] model_mem [2**AW];

  typedef struct {
    bit            is_unload;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;      // unload data or expected fetch data
    int            exp_lat;   // negedges from drive to pulse
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;
  endtask

  // Issue a fetch and check latency, data, pulse width and idle afterwards.
  task automatic do_fetch(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                          input int exp_lat, input string name);
    int n;
    bit got;
    n = 0;
    got = 0;
    bus.request_string = 1'b1;
    bus.fetch_address  = addr;
    while (!got && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
      if (bus.fetch_data_presented) got = 1;
    end
    bus.request_string = 1'b0;
    check({name, "_pulse"}, 32'(got), 32'd1);
    check({name, "_lat"},   32'(n), 32'(exp_lat));
    check({name, "_data"},  32'(bus.fetch_data), 32'(exp));
    @(negedge clk);
    check({name, "_onecyc"}, {30'd0, bus.fetch_data_presented, bus.busy}, 32'd0);
    check({name, "_hold"},  32'(bus.fetch_data), 32'(exp));
  endtask

  task automatic do_unload(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int exp_lat, input string name);
    int n;
    bit got;
    n = 0;
    got = 0;
    bus.unload_request = 1'b1;
    bus.unload_address = addr;
    bus.unload_data    = data;
    while (!got && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
      if (bus.unloaded_data_handled) got = 1;
    end
    bus.unload_request = 1'b0;
    model_mem[addr] = data;
    check({name, "_pulse"}, 32'(got), 32'd1);
    check({name, "_lat"},   32'(n), 32'(exp_lat));
    @(negedge clk);
    check({name, "_onecyc"}, {30'd0, bus.unloaded_data_handled, bus.busy}, 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check("rst_outputs", {bus.fetch_data_presented, bus.unloaded_data_handled, bus.busy, 29'd0}, 32'd0);
    check("rst_fetch_data", 32'(bus.fetch_data), 32'd0);
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t_handled;
    int t_present;
    bit quiet;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    reset = 1'b0;
    bus.request_string = 1'b0;
    bus.fetch_address  = '0;
    bus.unload_request = 1'b0;
    bus.unload_address = '0;
    bus.unload_data    = '0;

    vecs[0] = '{1'b0, 4'd3,  8'h00, RL + 1};
    vecs[1] = '{1'b1, 4'd5,  8'hA7, WL + 1};
    vecs[2] = '{1'b0, 4'd5,  8'hA7, RL + 1};
    vecs[3] = '{1'b1, 4'd0,  8'h11, WL + 1};
    vecs[4] = '{1'b1, 4'd15, 8'hEE, WL + 1};
    vecs[5] = '{1'b0, 4'd15, 8'hEE, RL + 1};
    vecs[6] = '{1'b0, 4'd0,  8'h11, RL + 1};

    @(negedge clk);
    apply_reset();

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_unload)
        do_unload(vecs[i].addr, vecs[i].data, vecs[i].exp_lat, $sformatf("vec%0d", i));
      else
        do_fetch(vecs[i].addr, vecs[i].data, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Unload and fetch raised together: unload is served first, then the fetch.
    bus.unload_request = 1'b1;
    bus.unload_address = 4'd9;
    bus.unload_data    = 8'h3C;
    bus.request_string = 1'b1;
    bus.fetch_address  = 4'd9;
    t_handled = 0;
    t_present = 0;
    n = 0;
    while (t_present == 0 && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
      if (bus.unloaded_data_handled && t_handled == 0) begin
        t_handled = n;
        bus.unload_request = 1'b0;
      end
      if (bus.fetch_data_presented) begin
        t_present = n;
        bus.request_string = 1'b0;
      end
    end
    model_mem[9] = 8'h3C;
    check("simul_handled_t", 32'(t_handled), 32'(WL + 1));
    check("simul_present_t", 32'(t_present), 32'(WL + 1 + 2 + RL));
    check("simul_data", 32'(bus.fetch_data), 32'h3C);
    @(negedge clk);

    // Fetch address changes after accept: the latched address is used.
    bus.request_string = 1'b1;
    bus.fetch_address  = 4'd5;
    @(negedge clk);
    bus.fetch_address  = 4'd7;
    n = 1;
    while (!bus.fetch_data_presented && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    bus.request_string = 1'b0;
    check("latch_lat", 32'(n), 32'(RL + 1));
    check("latch_data", 32'(bus.fetch_data), 32'hA7);
    @(negedge clk);

    // Random traffic against the memory model.
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, 2**AW - 1));
      d = DW'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_unload(a, d, WL + 1, $sformatf("rnd%0d_u", i));
      else
        do_fetch(a, model_mem[a], RL + 1, $sformatf("rnd%0d_f", i));
    end

    // Reset during READ_WAIT drops the fetch; array contents are cleared.
    do_unload(4'd2, 8'h55, WL + 1, "pre_rst_u");
    bus.request_string = 1'b1;
    bus.fetch_address  = 4'd2;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_idle", {bus.busy, bus.fetch_data_presented, 30'd0}, 32'd0);
    bus.request_string = 1'b0;
    clear_model();
    quiet = 1;
    repeat (3) begin
      @(negedge clk);
      if (bus.fetch_data_presented || bus.unloaded_data_handled || bus.busy) quiet = 0;
    end
    check("midrst_no_pulse", 32'(quiet), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    do_fetch(4'd2, model_mem[2], RL + 1, "post_rst_f");

`ifdef CASH_RESPONDER_STATS_EN
    apply_reset();
    check("stats_rst", {fetch_count, unload_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      do_fetch(AW'(i), model_mem[i], RL + 1, $sformatf("stat_f%0d", i));
    end
    check("stats_fetch_sat", 32'(fetch_count), 32'((5 < 2**SW - 1) ? 5 : 2**SW - 1));
    check("stats_unload", 32'(unload_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cash_backing_responder
`default_nettype wire
